branch_sequencer: RTL and testbench

Program-counter sequencer for the 8-bit CPU datapath. It fetches instruction words over a req/ack handshake and evaluates the 3-bit branch condition against the supplied register value. It then either steps the PC or loads the branch target. It sits between instruction memory and the condition-evaluation logic, and owns the PC, the taken-branch pulse and the run/halt status.

---
 rtl/branch_seq_pkg.sv | 25 ++
 rtl/branch_sequencer_cond_eval.sv | 34 +++
 rtl/branch_sequencer.sv | 113 +++++++++++
 tb/tb_branch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_seq_pkg.sv
// Shared types and constants for the branch sequencer: condition codes,
// FSM states and the taken-branch counter ceiling.
package branch_seq_pkg;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_EQZ    = 3'b001,
        COND_LTZ    = 3'b010,
        COND_LEZ    = 3'b011,
        COND_ALWAYS = 3'b100,
        COND_NEZ    = 3'b101,
        COND_GEZ    = 3'b110,
        COND_GTZ    = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [7:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational branch-condition evaluator: tests a two's-complement value
// against one of eight zero/sign conditions.
module cond_eval
    import branch_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] value,
    input  logic [2:0]        cond,
    output logic              result
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == '0);
    assign is_neg  = value[DATA_W-1];

    always_comb begin
        result = 1'b0;
        case (cond_e'(cond))
            COND_NEVER:  result = 1'b0;
            COND_EQZ:    result = is_zero;
            COND_LTZ:    result = is_neg;
            COND_LEZ:    result = is_neg | is_zero;
            COND_ALWAYS: result = 1'b1;
            COND_NEZ:    result = ~is_zero;
            COND_GEZ:    result = ~is_neg;
            COND_GTZ:    result = ~is_neg & ~is_zero;
            default:     result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: fetches over req/ack, evaluates the branch
// condition one cycle later, then steps the PC or loads the branch target.
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic              instr_is_branch,
    input  logic [2:0]        instr_cond,
    input  logic [ADDR_W-1:0] instr_target,
    input  logic [DATA_W-1:0] value,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        branch_count
);

    state_e              state_reg;
    logic                halt_flag_reg;
    logic                is_branch_reg;
    logic [2:0]          cond_reg;
    logic [ADDR_W-1:0]   target_reg;
    logic [DATA_W-1:0]   value_reg;
    logic                cond_true;
    logic                branch_hit;
    logic                self_loop;
    logic                stop_now;

    cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .value  (value_reg),
        .cond   (cond_reg),
        .result (cond_true)
    );

    assign fetch_addr = pc;
    assign branch_hit = is_branch_reg & cond_true;
    assign self_loop  = branch_hit && (target_reg == pc);
    // A halt_req arriving in EVAL itself is honoured at the end of this same EVAL.
    assign stop_now   = self_loop | halt_flag_reg | halt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            halt_flag_reg <= 1'b0;
            is_branch_reg <= 1'b0;
            cond_reg      <= 3'b000;
            target_reg    <= '0;
            value_reg     <= '0;
            pc            <= '0;
            fetch_req     <= 1'b0;
            taken         <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            branch_count  <= 8'd0;
        end else begin
            taken <= 1'b0;
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg    <= FETCH;
                        pc           <= '0;
                        branch_count <= 8'd0;
                        fetch_req    <= 1'b1;
                        busy         <= 1'b1;
                        halted       <= 1'b0;
                    end
                end
                FETCH: begin
                    if (halt_req)
                        halt_flag_reg <= 1'b1;
                    if (fetch_ack) begin
                        is_branch_reg <= instr_is_branch;
                        cond_reg      <= instr_cond;
                        target_reg    <= instr_target;
                        value_reg     <= value;
                        fetch_req     <= 1'b0;
                        state_reg     <= EVAL;
                    end
                end
                EVAL: begin
                    if (branch_hit) begin
                        pc    <= target_reg;
                        taken <= 1'b1;
                        if (branch_count != COUNT_MAX)
                            branch_count <= branch_count + 8'd1;
                    end else begin
                        pc <= pc + ADDR_W'(1);
                    end
                    if (stop_now) begin
                        state_reg     <= HALT;
                        halt_flag_reg <= 1'b0;
                        busy          <= 1'b0;
                        halted        <= 1'b1;
                    end else begin
                        state_reg <= FETCH;
                        fetch_req <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed-vector bench for branch_sequencer: sequential fetch, branch
// conditions, counter saturation, PC wrap, self-loop/halt and async reset.
module tb_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ack = 1'b0;
    logic       instr_is_branch = 1'b0;
    logic [2:0] instr_cond = 3'b000;
    logic [7:0] instr_target = 8'h00;
    logic [7:0] value = 8'h00;
    logic [7:0] pc;
    logic       taken;
    logic       busy;
    logic       halted;
    logic [7:0] branch_count;

    int errors = 0;
    int checks = 0;
    logic       eval_freq;
    logic [7:0] pc_model;
    logic [7:0] cnt_model;

    // Expected taken per condition, value order {00, 01, 7F, 80, FF} left to right.
    logic [4:0] exp_tab [0:7] = '{5'b00000, 5'b10000, 5'b00011, 5'b10011,
                                  5'b11111, 5'b01111, 5'b11100, 5'b01100};
    logic [7:0] vals [0:4] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    branch_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .halt_req        (halt_req),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .instr_is_branch (instr_is_branch),
        .instr_cond      (instr_cond),
        .instr_target    (instr_target),
        .value           (value),
        .pc              (pc),
        .taken           (taken),
        .busy            (busy),
        .halted          (halted),
        .branch_count    (branch_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One instruction: optional ack delay, ack cycle, then EVAL; returns one
    // cycle after EVAL with eval_freq holding fetch_req seen during EVAL.
    task automatic exec(input logic br, input logic [2:0] c, input logic [7:0] tgt,
                        input logic [7:0] v, input int delay);
        checks++;
        if (fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL exec_entry_fetch_req: got %b expected 1", fetch_req);
        end
        repeat (delay) tick();
        fetch_ack = 1'b1;
        instr_is_branch = br;
        instr_cond = c;
        instr_target = tgt;
        value = v;
        tick();
        fetch_ack = 1'b0;
        instr_is_branch = 1'b0;
        eval_freq = fetch_req;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({pc, fetch_req, taken, busy, halted, branch_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got pc=%h req=%b tk=%b busy=%b halt=%b cnt=%h expected all zero",
                     pc, fetch_req, taken, busy, halted, branch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_ack = 1'b1;
        tick();
        tick();
        fetch_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got busy=%b req=%b expected 0/0", busy, fetch_req);
        end
        $display("test_reset done");
    endtask

    task automatic test_sequential;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (fetch_req !== 1'b1 || pc !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_fetch: got req=%b pc=%h busy=%b expected 1/00/1", fetch_req, pc, busy);
        end
        for (int i = 0; i < 3; i++) begin
            exec(1'b0, 3'b100, 8'hAA, 8'h00, 0);
            checks++;
            if (pc !== 8'(i + 1) || taken !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc_%0d: got pc=%h taken=%b expected %h/0", i, pc, taken, 8'(i + 1));
            end
            checks++;
            if (eval_freq !== 1'b0 || fetch_req !== 1'b1) begin
                errors++;
                $display("FAIL seq_req_pattern_%0d: got eval=%b next=%b expected 0/1", i, eval_freq, fetch_req);
            end
        end
        $display("test_sequential done pc=%h", pc);
    endtask

    task automatic test_branch;
        exec(1'b1, 3'b010, 8'h40, 8'h80, 0);
        checks++;
        if (taken !== 1'b1 || pc !== 8'h40 || branch_count !== 8'd1) begin
            errors++;
            $display("FAIL branch_lt_taken: got tk=%b pc=%h cnt=%0d expected 1/40/1", taken, pc, branch_count);
        end
        tick();
        checks++;
        if (taken !== 1'b0) begin
            errors++;
            $display("FAIL taken_one_cycle: got %b expected 0", taken);
        end
        exec(1'b1, 3'b010, 8'h99, 8'h7F, 0);
        checks++;
        if (taken !== 1'b0 || pc !== 8'h41 || branch_count !== 8'd1) begin
            errors++;
            $display("FAIL branch_lt_not_taken: got tk=%b pc=%h cnt=%0d expected 0/41/1", taken, pc, branch_count);
        end
        pc_model = 8'h41;
        cnt_model = 8'd1;
        $display("test_branch done");
    endtask

    task automatic test_cond_sweep;
        logic [7:0] tgt;
        logic       exp;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 5; j++) begin
                tgt = pc_model + 8'h20;
                exec(1'b1, 3'(c), tgt, vals[j], 0);
                exp = exp_tab[c][4 - j];
                pc_model = exp ? tgt : pc_model + 8'd1;
                cnt_model = cnt_model + 8'(exp);
                checks++;
                if (taken !== exp || pc !== pc_model) begin
                    errors++;
                    $display("FAIL sweep_c%0d_v%h: got tk=%b pc=%h expected %b/%h", c, vals[j], taken, pc, exp, pc_model);
                end
            end
        end
        checks++;
        if (branch_count !== cnt_model) begin
            errors++;
            $display("FAIL sweep_count: got %0d expected %0d", branch_count, cnt_model);
        end
        $display("test_cond_sweep done count=%0d", branch_count);
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 240; k++) begin
            exec(1'b1, 3'b100, pc_model + 8'h20, 8'h00, 0);
            pc_model = pc_model + 8'h20;
            if (k == 232) begin
                checks++;
                if (branch_count !== 8'd254) begin
                    errors++;
                    $display("FAIL count_254: got %0d expected 254", branch_count);
                end
            end
        end
        checks++;
        if (branch_count !== 8'd255) begin
            errors++;
            $display("FAIL count_saturate: got %0d expected 255", branch_count);
        end
        $display("test_saturation done count=%0d", branch_count);
    endtask

    task automatic test_wrap_selfloop;
        logic [7:0] t1;
        t1 = (pc_model == 8'h10) ? 8'h11 : 8'h10;
        exec(1'b1, 3'b100, t1, 8'h00, 0);
        exec(1'b1, 3'b100, 8'hFF, 8'h00, 0);
        checks++;
        if (pc !== 8'hFF || fetch_addr !== 8'hFF) begin
            errors++;
            $display("FAIL pc_ff: got pc=%h addr=%h expected ff", pc, fetch_addr);
        end
        exec(1'b0, 3'b000, 8'h00, 8'h00, 0);
        checks++;
        if (pc !== 8'h00 || busy !== 1'b1 || fetch_req !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h busy=%b req=%b halt=%b expected 00/1/1/0", pc, busy, fetch_req, halted);
        end
        exec(1'b1, 3'b100, 8'h00, 8'h00, 0);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || taken !== 1'b1 || pc !== 8'h00 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL self_loop_halt: got halt=%b busy=%b tk=%b pc=%h req=%b expected 1/0/1/00/0",
                     halted, busy, taken, pc, fetch_req);
        end
        $display("test_wrap_selfloop done");
    endtask

    task automatic test_halt_req;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 8'h00 || branch_count !== 8'd0 || fetch_req !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_halt: got pc=%h cnt=%0d req=%b halt=%b expected 00/0/1/0",
                     pc, branch_count, fetch_req, halted);
        end
        exec(1'b0, 3'b000, 8'h00, 8'h00, 0);
        checks++;
        if (halted !== 1'b0 || fetch_req !== 1'b1 || pc !== 8'h01) begin
            errors++;
            $display("FAIL halt_req_ignored_in_halt: got halt=%b req=%b pc=%h expected 0/1/01", halted, fetch_req, pc);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        checks++;
        if (fetch_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_not_aborted: got req=%b busy=%b expected 1/1", fetch_req, busy);
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        checks++;
        if (fetch_req !== 1'b0 || busy !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_req_eval: got req=%b busy=%b halt=%b expected 0/1/0", fetch_req, busy, halted);
        end
        tick();
        checks++;
        if (pc !== 8'h02 || halted !== 1'b1 || busy !== 1'b0 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_req_halted: got pc=%h halt=%b busy=%b req=%b expected 02/1/0/0", pc, halted, busy, fetch_req);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc !== 8'h00 || branch_count !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_halt_req: got pc=%h cnt=%0d busy=%b expected 00/0/1", pc, branch_count, busy);
        end
        $display("test_halt_req done");
    endtask

    task automatic test_async_reset;
        exec(1'b1, 3'b100, 8'h33, 8'h00, 0);
        checks++;
        if (pc !== 8'h33 || branch_count !== 8'd1 || fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got pc=%h cnt=%0d req=%b expected 33/1/1", pc, branch_count, fetch_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, fetch_req, taken, busy, halted, branch_count} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h req=%b tk=%b busy=%b halt=%b cnt=%h expected all zero",
                     pc, fetch_req, taken, busy, halted, branch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b req=%b expected 0/0", busy, fetch_req);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        exec(1'b0, 3'b000, 8'h00, 8'h00, 0);
        checks++;
        if (pc !== 8'h01 || fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset: got pc=%h req=%b expected 01/1", pc, fetch_req);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        pc_model = 8'h00;
        cnt_model = 8'd0;
        eval_freq = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_cond_sweep();
        test_saturation();
        test_wrap_selfloop();
        test_halt_req();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
